// File: rtl/vending_machine_pkg.sv
// Shared types for the 15c vending controller: credit state encoding and coin codes.
package vending_machine_pkg;

  typedef enum logic [1:0] {
    S0        = 2'b00,
    S5        = 2'b01,
    S10       = 2'b10,
    S_ILLEGAL = 2'b11
  } state_e;

  localparam logic [1:0] NONE   = 2'b00;
  localparam logic [1:0] NICKEL = 2'b01;
  localparam logic [1:0] DIME   = 2'b10;

endpackage

// File: rtl/vending_machine.sv
// Coin-operated vending FSM: tracks 0/5/10c credit, pulses dispense at >=15c and change at 20c.
module vending_machine
  import vending_machine_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] money,
  output logic       dispense,
  output logic       change,
  output logic [1:0] current_state
);

  state_e state_q, state_d;
  logic   dispense_q, dispense_d;
  logic   change_q, change_d;

  // Invalid coin code 11 falls into the default arms and behaves like no coin.
  always_comb begin
    state_d    = state_q;
    dispense_d = 1'b0;
    change_d   = 1'b0;
    case (state_q)
      S0: begin
        case (money)
          NICKEL:  state_d = S5;
          DIME:    state_d = S10;
          default: state_d = S0;
        endcase
      end
      S5: begin
        case (money)
          NICKEL: state_d = S10;
          DIME: begin
            state_d    = S0;
            dispense_d = 1'b1;
          end
          default: state_d = S5;
        endcase
      end
      S10: begin
        case (money)
          NICKEL: begin
            state_d    = S0;
            dispense_d = 1'b1;
          end
          DIME: begin
            state_d    = S0;
            dispense_d = 1'b1;
            change_d   = 1'b1;
          end
          default: state_d = S10;
        endcase
      end
      default: state_d = S0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S0;
      dispense_q <= 1'b0;
      change_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dispense_q <= dispense_d;
      change_q   <= change_d;
    end
  end

  assign current_state = state_q;
  assign dispense      = dispense_q;
  assign change        = change_q;

endmodule

// File: tb/tb_vending_machine.sv
// Scoreboard bench: stimulus pushes expected outputs from a cents-based credit model; a monitor pops and compares.
module tb_vending_machine;

  logic       clk;
  logic       rst;
  logic [1:0] money;
  logic       dispense;
  logic       change;
  logic [1:0] current_state;

  typedef struct packed {
    logic [1:0] st;
    logic       d;
    logic       c;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   credit = 0;

  vending_machine dut (
    .clk           (clk),
    .rst           (rst),
    .money         (money),
    .dispense      (dispense),
    .change        (change),
    .current_state (current_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Reference: credit in cents; a coin adds its value, a purchase at >=15c clears it.
  task automatic drive(input logic [1:0] m);
    int   val;
    exp_t e;
    @(negedge clk);
    money = m;
    val = (m == 2'b01) ? 5 : (m == 2'b10) ? 10 : 0;
    credit = credit + val;
    e.d = 1'b0;
    e.c = 1'b0;
    if (credit >= 15) begin
      e.d = 1'b1;
      e.c = (credit - 15 == 5);
      credit = 0;
    end
    e.st = 2'(credit / 5);
    exp_q.push_back(e);
    $display("coin %b -> expect state=%b disp=%b chg=%b", m, e.st, e.d, e.c);
  endtask

  // Asserts reset between edges, checks immediate and held clearing, then releases.
  task automatic async_reset(input int cycles);
    @(negedge clk);
    #2;
    rst = 1'b0;
    credit = 0;
    #1;
    check("rst_imm_state", current_state, 2'b00);
    check("rst_imm_disp", {1'b0, dispense}, 2'b00);
    check("rst_imm_chg", {1'b0, change}, 2'b00);
    money = 2'b10;
    repeat (cycles) begin
      @(negedge clk);
      check("rst_hold_state", current_state, 2'b00);
      check("rst_hold_pulses", {dispense, change}, 2'b00);
    end
    money = 2'b00;
    rst = 1'b1;
    $display("reset released");
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state", current_state, e.st);
        check("dispense", {1'b0, dispense}, {1'b0, e.d});
        check("change", {1'b0, change}, {1'b0, e.c});
      end
    end
  end

  initial begin : stim
    int n;
    rst   = 1'b0;
    money = 2'b10;
    repeat (3) begin
      @(negedge clk);
      check("init_rst_state", current_state, 2'b00);
      check("init_rst_pulses", {dispense, change}, 2'b00);
    end
    money = 2'b00;
    rst   = 1'b1;
    drive(2'b00);
    // dime, idle, idle, nickel
    drive(2'b10); drive(2'b00); drive(2'b00); drive(2'b01); drive(2'b00);
    // dime, dime
    drive(2'b10); drive(2'b10); drive(2'b00);
    // three nickels
    drive(2'b01); drive(2'b01); drive(2'b01); drive(2'b00);
    // nickel, dime; invalid code in S5
    drive(2'b01); drive(2'b10);
    drive(2'b01); drive(2'b11); drive(2'b11); drive(2'b00); drive(2'b10);
    // reset mid-transaction at 10c
    drive(2'b10);
    async_reset(2);
    drive(2'b01); drive(2'b00); drive(2'b01); drive(2'b01);
    // randomized coins with occasional resets
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) async_reset($urandom_range(1, 3));
      drive(2'($urandom_range(0, 3)));
    end
    @(negedge clk);
    money = 2'b00;
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vending_machine.md
Name: vending_machine

Overview:
- Coin-operated vending controller FSM. One item costs 15 cents.
- Accepts one coin code per clock: nickel (5c) or dime (10c).
- Issues a one-cycle dispense pulse when the accumulated credit reaches 15c or more, and a one-cycle change pulse when the credit reaches 20c (5c overpay).
- Exposes its credit state for debug and monitoring. Sits between the coin-acceptor front end and the dispenser and change actuators.

Parameters:
- None. Price (15c), coin values and encodings are fixed.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- money  input  2  coin code sampled each rising edge: 00 = no coin, 01 = nickel (5c), 10 = dime (10c), 11 = invalid.
- dispense  output  1  registered; high for exactly one cycle when a purchase completes.
- change  output  1  registered; high for exactly one cycle when 5c is returned.
- current_state  output  2  registered credit state: 00 = 0c, 01 = 5c, 10 = 10c.

Behaviour:
- Reset:
  - rst low immediately forces current_state = 00, dispense = 0, change = 0, regardless of clk.
  - Outputs hold these values while rst is low. The first update happens at the first rising edge after rst goes high.
- States: S0 = 00 (0c), S5 = 01 (5c), S10 = 10 (10c). Encoding 11 is illegal.
- Transitions, evaluated on the rising edge using the money value sampled at that edge:
  - S0: 00 -> S0; 01 -> S5; 10 -> S10.
  - S5: 00 -> S5; 01 -> S10; 10 -> S0 with dispense = 1.
  - S10: 00 -> S10; 01 -> S0 with dispense = 1; 10 -> S0 with dispense = 1 and change = 1.
  - money = 11 in any legal state: treated as no coin. State holds, no pulses.
  - Illegal state 11: next edge goes to S0 with no pulses, whatever money is.
- dispense and change are registered outputs:
  - Asserted in the cycle after the completing edge, i.e. at the same time current_state shows S0.
  - Deasserted at the following edge unless another purchase completes on it.
  - change is never high without dispense.
- Credit never exceeds 10c between cycles. No coin is lost, and overpay is at most 5c.
- A coin held on money for several edges counts once per edge. The upstream acceptor guarantees single-cycle coin codes.
- Reset asserted mid-transaction discards the credit. No pulse is produced for that transaction.

Decomposition:
- Shared package holds:
  - state typedef (S0, S5, S10) as 2-bit localparams/enums;
  - coin code constants NONE = 00, NICKEL = 01, DIME = 10.
- One module with a separate next-state/output combinational block and a state/output register block. No sub-module.

Test Plan:
- Reset: rst = 0 with money = 10 and clock running -> current_state = 00, dispense = 0, change = 0 throughout. After release, the first edge with money = 00 keeps S0.
- Dime then nickel: money 10 for one edge -> state 10; money 00 for two edges -> holds 10, no pulses; money 01 -> state 00, dispense = 1 for one cycle, change = 0.
- Dime then dime: 10, 10 -> after second edge state 00, dispense = 1 and change = 1 for one cycle, then both 0.
- Three nickels: 01, 01, 01 -> states 01, 10, 00; dispense pulse only after the third edge; change = 0.
- Nickel then dime: 01, 10 -> states 01, 00; dispense = 1, change = 0. Invalid code 11 in S5 -> state stays 01, no pulses.
- Reset mid-transaction: state 10, then rst low between edges -> current_state = 00 immediately (asynchronous). After release, a nickel gives state 01 and no dispense.
